spi_slave_core: RTL and testbench

SPI mode-3 slave (SCK idles high; data changes on the falling edge and is sampled on the rising edge), transferring bytes LSB first.
- All SPI inputs are synchronised into the single system clock domain i_clk; all logic runs on i_clk.
- Received bytes go to the host logic with a one-cycle ready pulse.
- The host loads transmit bytes through a one-cycle load strobe.
- Sits between the board SPI pins and the byte-level command logic.

---
 rtl/spi_slave_core.sv | 110 +++++++++++
 tb/tb_spi_slave_core.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_core.sv
// SPI mode-3 slave, LSB first, fully synchronised into i_clk.
// Define SPI_SLAVE_MISO_HIZ_EN to tri-state o_MISO while deselected or in reset.
module spi_slave_core #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       i_clk,
  input  logic       i_sys_rst,
  input  logic       i_sck,
  input  logic       i_MOSI,
  input  logic       i_cs,
  output logic       o_MISO,
  output logic [7:0] o_rx_byte,
  output logic       o_rx_rdy,
  input  logic [7:0] i_tx_byte,
  input  logic       i_tx_rdy
);

  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic [SYNC_STAGES-1:0] cs_sync;

  logic       sck_s, mosi_s, cs_s;
  logic       sck_q, cs_q;
  logic       sck_rise, sck_fall;
  logic       cs_fall, cs_rise;
  logic [2:0] cnt;
  logic       last_bit;
  logic [7:0] rx_sh;
  logic [7:0] tx_sh;
  logic [7:0] hold;
  logic [7:0] tx_next;
  logic       pend;

  always_ff @(posedge i_clk) begin
    if (i_sys_rst) begin
      sck_sync  <= '1;
      cs_sync   <= '1;
      mosi_sync <= '0;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], i_sck};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], i_cs};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], i_MOSI};
    end
  end

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];

  assign sck_rise = sck_s & ~sck_q & ~cs_s;
  assign sck_fall = ~sck_s & sck_q & ~cs_s;
  assign cs_fall  = ~cs_s & cs_q;
  assign cs_rise  = cs_s & ~cs_q;
  assign last_bit = (cnt == 3'd7);
  assign tx_next  = i_tx_rdy ? i_tx_byte : hold;

  // pend keeps bit0 on the line through the first falling edge after a load
  always_ff @(posedge i_clk) begin
    if (i_sys_rst) begin
      sck_q     <= 1'b1;
      cs_q      <= 1'b1;
      cnt       <= 3'd0;
      rx_sh     <= 8'h00;
      tx_sh     <= 8'h00;
      hold      <= 8'h00;
      pend      <= 1'b0;
      o_rx_byte <= 8'h00;
      o_rx_rdy  <= 1'b0;
    end else begin
      sck_q    <= sck_s;
      cs_q     <= cs_s;
      o_rx_rdy <= 1'b0;
      if (i_tx_rdy) hold <= i_tx_byte;
      if (cs_rise) begin
        cnt   <= 3'd0;
        rx_sh <= 8'h00;
        tx_sh <= 8'h00;
        pend  <= 1'b0;
      end else begin
        if (cs_fall) begin
          tx_sh <= tx_next;
          hold  <= 8'h00;
          pend  <= 1'b1;
        end
        if (sck_rise) begin
          rx_sh <= {mosi_s, rx_sh[7:1]};
          cnt   <= cnt + 3'd1;
          if (last_bit) begin
            cnt       <= 3'd0;
            o_rx_byte <= {mosi_s, rx_sh[7:1]};
            o_rx_rdy  <= 1'b1;
            tx_sh     <= tx_next;
            hold      <= 8'h00;
            pend      <= 1'b1;
          end
        end else if (sck_fall) begin
          if (pend) pend <= 1'b0;
          else tx_sh <= {1'b0, tx_sh[7:1]};
        end
      end
    end
  end

`ifdef SPI_SLAVE_MISO_HIZ_EN
  assign o_MISO = (cs_s || i_sys_rst) ? 1'bz : tx_sh[0];
`else
  assign o_MISO = cs_s ? 1'b0 : tx_sh[0];
`endif

endmodule

// File: tb/tb_spi_slave_core.sv
// Scoreboard bench for spi_slave_core: rx bytes checked by a monitor,
// tx bytes checked as the master assembles them.
module tb_spi_slave_core;

  localparam int HALF = 6;
  localparam int GAP  = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sck = 1'b1;
  logic       mosi = 1'b0;
  logic       cs = 1'b1;
  logic       miso;
  logic [7:0] rx_byte;
  logic       rx_rdy;
  logic [7:0] tx_byte = 8'h00;
  logic       tx_rdy = 1'b0;

  int n_checks = 0;
  int n_fail = 0;
  logic [7:0] exp_rx[$];
  logic [7:0] exp_tx[$];
  logic prev_rdy = 1'b0;

  spi_slave_core #(.SYNC_STAGES(2)) dut (
    .i_clk(clk),
    .i_sys_rst(rst),
    .i_sck(sck),
    .i_MOSI(mosi),
    .i_cs(cs),
    .o_MISO(miso),
    .o_rx_byte(rx_byte),
    .o_rx_rdy(rx_rdy),
    .i_tx_byte(tx_byte),
    .i_tx_rdy(tx_rdy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (rx_rdy) begin
        n_checks++;
        if (prev_rdy) begin
          n_fail++;
          $display("FAIL rx_rdy_width: got 2+ cycles expected 1");
        end else if (exp_rx.size() == 0) begin
          n_fail++;
          $display("FAIL rx_spurious: got pulse byte %h expected none",
                   rx_byte);
        end else begin
          logic [7:0] e;
          e = exp_rx.pop_front();
          if (rx_byte !== e) begin
            n_fail++;
            $display("FAIL rx_byte: got %h expected %h", rx_byte, e);
          end
        end
      end
      prev_rdy <= rx_rdy;
    end
  end

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input logic [7:0] b);
    @(negedge clk);
    tx_byte = b;
    tx_rdy = 1'b1;
    @(negedge clk);
    tx_rdy = 1'b0;
  endtask

  task automatic cs_low();
    @(negedge clk);
    cs = 1'b0;
    clks(HALF);
  endtask

  task automatic cs_high();
    clks(HALF);
    cs = 1'b1;
    clks(GAP);
  endtask

  task automatic spi_byte(input logic [7:0] mb, input int nbits,
                          input bit ld, input logic [7:0] lv,
                          output logic [7:0] sb);
    sb = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      sck = 1'b0;
      mosi = mb[i];
      clks(HALF);
      sck = 1'b1;
      sb[i] = miso;
      for (int j = 0; j < HALF; j++) begin
        if (ld && i == 3 && j == 0) begin
          tx_byte = lv;
          tx_rdy = 1'b1;
        end else begin
          tx_rdy = 1'b0;
        end
        @(negedge clk);
      end
      tx_rdy = 1'b0;
    end
  endtask

  task automatic full_byte(input logic [7:0] mb);
    logic [7:0] sb;
    exp_rx.push_back(mb);
    spi_byte(mb, 8, 1'b0, 8'h00, sb);
    check("miso_byte", sb, exp_tx.pop_front());
  endtask

  initial begin
    logic [7:0] sb;
    clks(3);
    check("rst_rx_byte", rx_byte, 8'h00);
    check("rst_rx_rdy", {7'd0, rx_rdy}, 8'h00);
    check("rst_miso", {7'd0, miso}, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    clks(4);

    exp_tx.push_back(8'h00);
    cs_low();
    full_byte(8'hA5);
    cs_high();
    check("hold_a5", rx_byte, 8'hA5);

    load(8'h3C);
    exp_tx.push_back(8'h3C);
    cs_low();
    full_byte(8'h00);
    cs_high();
    exp_tx.push_back(8'h00);
    cs_low();
    full_byte(8'hFF);
    cs_high();

    load(8'h56);
    cs_low();
    exp_rx.push_back(8'h12);
    spi_byte(8'h12, 8, 1'b1, 8'h78, sb);
    check("b2b_tx0", sb, 8'h56);
    exp_rx.push_back(8'h34);
    spi_byte(8'h34, 8, 1'b0, 8'h00, sb);
    check("b2b_tx1", sb, 8'h78);
    cs_high();
    check("b2b_rx_last", rx_byte, 8'h34);

    cs_low();
    spi_byte(8'hFF, 5, 1'b0, 8'h00, sb);
    cs_high();
    check("abort_hold", rx_byte, 8'h34);
    check("abort_miso", {7'd0, miso}, 8'h00);
    exp_tx.push_back(8'h00);
    cs_low();
    full_byte(8'h81);
    cs_high();
    check("after_abort", rx_byte, 8'h81);

    cs_low();
    spi_byte(8'hFF, 4, 1'b0, 8'h00, sb);
    @(negedge clk);
    rst = 1'b1;
    clks(3);
    rst = 1'b0;
    check("midrst_rx", rx_byte, 8'h00);
    cs_high();
    exp_tx.push_back(8'h00);
    cs_low();
    full_byte(8'h7E);
    cs_high();
    check("after_rst", rx_byte, 8'h7E);

    for (int b = 0; b < 255; b++) begin
      exp_tx.push_back(8'h00);
      cs_low();
      full_byte(8'(b));
      cs_high();
    end
    check("sweep_last", rx_byte, 8'hFE);

    clks(GAP);
    check("rx_pending", 8'(exp_rx.size()), 8'h00);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
